regfile_writeback_queue: RTL and testbench

- Write-side front end for the 32 x 16-bit register file.
- Accepts results from two producers:
  - the ALU: single-cycle, never stalled;
  - the load unit: valid/ready, buffered in a small in-order queue.
- Issues at most one registered write per cycle on the register file write port (enable, destination, value).
- Kills stale queued load results, and exposes a forwarding lookup so decode sees values not yet committed.

---
 rtl/regfile_writeback_queue.sv | 141 ++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Register file write-side front end: ALU results take priority, load results wait
// in a small in-order queue, stale loads are killed, and pending values are forwarded.
module regfile_writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_alu_valid,
    input  logic [ADDR_W-1:0]         i_alu_dest,
    input  logic [DATA_W-1:0]         i_alu_val,
    input  logic                      i_ld_valid,
    output logic                      o_ld_ready,
    input  logic [ADDR_W-1:0]         i_ld_dest,
    input  logic [DATA_W-1:0]         i_ld_val,
    input  logic [ADDR_W-1:0]         i_query_reg,
    output logic                      o_query_hit,
    output logic [DATA_W-1:0]         o_query_val,
    output logic                      o_write_enable,
    output logic [ADDR_W-1:0]         o_dest,
    output logic [DATA_W-1:0]         o_write_val,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
    output logic                      o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] ent_dest_q [DEPTH];
    logic [ADDR_W-1:0] ent_dest_d [DEPTH];
    logic [DATA_W-1:0] ent_val_q  [DEPTH];
    logic [DATA_W-1:0] ent_val_d  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wdest_q, wdest_d;
    logic [DATA_W-1:0] wval_q, wval_d;

    logic              ld_accept;
    logic              pop;
    logic [PTR_W-1:0]  fwd_idx;

    assign o_full         = (count_q == CNT_W'(DEPTH));
    assign o_empty        = (count_q == '0);
    assign o_ld_ready     = !i_rst && !o_full;
    assign o_count        = count_q;
    assign o_write_enable = we_q;
    assign o_dest         = wdest_q;
    assign o_write_val    = wval_q;

    always_comb begin
        live_d     = live_q;
        ent_dest_d = ent_dest_q;
        ent_val_d  = ent_val_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        wdest_d    = wdest_q;
        wval_d     = wval_q;
        ld_accept  = i_ld_valid && o_ld_ready;
        pop        = !i_alu_valid && !o_empty;

        if (i_alu_valid) begin
            we_d    = 1'b1;
            wdest_d = i_alu_dest;
            wval_d  = i_alu_val;
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_dest_q[i] == i_alu_dest) live_d[i] = 1'b0;
            end
        end else if (pop) begin
            if (live_q[rd_ptr_q]) begin
                we_d    = 1'b1;
                wdest_d = ent_dest_q[rd_ptr_q];
                wval_d  = ent_val_q[rd_ptr_q];
            end
            // Popped slots drop their live bit so only occupied slots can forward.
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // A same-cycle load to the ALU's dest is older than the ALU result.
        if (ld_accept) begin
            live_d[wr_ptr_q]     = !(i_alu_valid && (i_ld_dest == i_alu_dest));
            ent_dest_d[wr_ptr_q] = i_ld_dest;
            ent_val_d[wr_ptr_q]  = i_ld_val;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (ld_accept && !pop)      count_d = count_q + CNT_W'(1);
        else if (!ld_accept && pop) count_d = count_q - CNT_W'(1);
    end

    // Walk oldest to youngest so the youngest live match is the one left standing.
    always_comb begin
        o_query_hit = 1'b0;
        o_query_val = '0;
        fwd_idx     = '0;
        if (we_q && (wdest_q == i_query_reg)) begin
            o_query_hit = 1'b1;
            o_query_val = wval_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (live_q[fwd_idx] && (ent_dest_q[fwd_idx] == i_query_reg)) begin
                o_query_hit = 1'b1;
                o_query_val = ent_val_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wdest_q  <= '0;
            wval_q   <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wdest_q  <= wdest_d;
            wval_q   <= wval_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ent_dest_q <= ent_dest_d;
        ent_val_q  <= ent_val_d;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: directed scenarios then random traffic,
// all expectations from a queue-level reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_dest = '0;
    logic [15:0] i_alu_val = '0;
    logic        i_ld_valid = 1'b0;
    logic        o_ld_ready;
    logic [4:0]  i_ld_dest = '0;
    logic [15:0] i_ld_val = '0;
    logic [4:0]  i_query_reg = '0;
    logic        o_query_hit;
    logic [15:0] o_query_val;
    logic        o_write_enable;
    logic [4:0]  o_dest;
    logic [15:0] o_write_val;
    logic [2:0]  o_count;
    logic        o_empty;
    logic        o_full;

    regfile_writeback_queue #(.DATA_W(16), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_alu_valid(i_alu_valid), .i_alu_dest(i_alu_dest), .i_alu_val(i_alu_val),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_dest(i_ld_dest), .i_ld_val(i_ld_val),
        .i_query_reg(i_query_reg), .o_query_hit(o_query_hit), .o_query_val(o_query_val),
        .o_write_enable(o_write_enable), .o_dest(o_dest), .o_write_val(o_write_val),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        logic [4:0]  dest;
        logic [15:0] val;
    } ent_t;

    typedef struct {
        logic [4:0]  dest;
        logic [15:0] val;
    } wr_t;

    ent_t mq[$];
    wr_t  exp_q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [15:0] m_val = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit running = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every DUT write must match the oldest expected write.
    initial begin
        wr_t w;
        while (running) begin
            @(negedge clk);
            if (o_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {27'd0, o_dest}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_dest", {27'd0, o_dest}, {27'd0, w.dest});
                    chk("write_val", {16'd0, o_write_val}, {16'd0, w.val});
                end
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("missing_write", {27'd0, w.dest}, 32'hFFFF_FFFF);
                exp_q.delete();
            end
        end
    end

    task automatic step(input logic rst, input logic av, input logic [4:0] ad, input logic [15:0] aval,
                        input logic lv, input logic [4:0] ldd, input logic [15:0] ldv,
                        input logic [4:0] q);
        logic        exp_ready, accept, exp_hit;
        logic [15:0] exp_fv;
        ent_t        e;
        @(negedge clk);
        i_rst = rst; i_alu_valid = av; i_alu_dest = ad; i_alu_val = aval;
        i_ld_valid = lv; i_ld_dest = ldd; i_ld_val = ldv; i_query_reg = q;
        #1;
        exp_ready = !rst && (mq.size() < DEPTH);
        chk("ld_ready", {31'd0, o_ld_ready}, {31'd0, exp_ready});
        chk("count", {29'd0, o_count}, mq.size());
        chk("empty", {31'd0, o_empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, o_full}, {31'd0, mq.size() == DEPTH});
        exp_hit = m_we && (m_dest == q);
        exp_fv  = exp_hit ? m_val : 16'd0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].dest == q) begin
                exp_hit = 1'b1;
                exp_fv  = mq[i].val;
            end
        end
        chk("query_hit", {31'd0, o_query_hit}, {31'd0, exp_hit});
        chk("query_val", {16'd0, o_query_val}, {16'd0, exp_fv});
        accept = lv && exp_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_dest = '0; m_val = '0;
        end else begin
            if (av) begin
                foreach (mq[i]) if (mq[i].dest == ad) mq[i].live = 1'b0;
                exp_q.push_back('{dest: ad, val: aval});
                m_we = 1'b1; m_dest = ad; m_val = aval;
            end else if (mq.size() != 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    exp_q.push_back('{dest: e.dest, val: e.val});
                    m_we = 1'b1; m_dest = e.dest; m_val = e.val;
                end else begin
                    m_we = 1'b0;
                end
            end else begin
                m_we = 1'b0;
            end
            if (accept) mq.push_back('{live: !(av && ldd == ad), dest: ldd, val: ldv});
        end
    endtask

    task automatic idle(input int n, input logic [4:0] q);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, q);
    endtask

    initial begin
        @(posedge clk);
        // Reset held with ALU traffic present
        step(1'b1, 1'b1, 5'd3, 16'h1234, 1'b1, 5'd4, 16'h5555, 5'd3);
        step(1'b1, 1'b1, 5'd3, 16'h1234, 1'b1, 5'd4, 16'h5555, 5'd3);
        #1;
        chk("rst_we", {31'd0, o_write_enable}, 32'd0);
        chk("rst_dest", {27'd0, o_dest}, 32'd0);
        chk("rst_val", {16'd0, o_write_val}, 32'd0);
        idle(1, 5'd0);

        // ALU priority over a queued load
        step(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h1111, 5'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd5, 16'hAAAA, 1'b0, 5'd0, 16'h0, 5'd3);
        idle(3, 5'd5);

        // Backpressure under continuous ALU traffic to r1
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 5'd1, 16'h00F0 + 16'(i), 1'b1, 5'(2 * i + 2), 16'h0100 + 16'(i), 5'd6);
        step(1'b0, 1'b1, 5'd1, 16'h00FF, 1'b1, 5'd10, 16'h0104, 5'd10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd10, 16'h0104, 5'd10);
        idle(6, 5'd10);

        // Kill of a queued entry, then same-cycle kill
        step(1'b0, 1'b1, 5'd0, 16'h0, 1'b1, 5'd7, 16'h0007, 5'd7);
        step(1'b0, 1'b1, 5'd7, 16'h0077, 1'b0, 5'd0, 16'h0, 5'd7);
        idle(3, 5'd7);
        step(1'b0, 1'b1, 5'd9, 16'h0099, 1'b1, 5'd9, 16'h0009, 5'd9);
        idle(3, 5'd9);

        // Forwarding: two loads to r4 behind ALU stall to r0
        step(1'b0, 1'b1, 5'd0, 16'h0, 1'b1, 5'd4, 16'h0001, 5'd4);
        step(1'b0, 1'b1, 5'd0, 16'h0, 1'b1, 5'd4, 16'h0002, 5'd4);
        step(1'b0, 1'b1, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 5'd4);
        #1;
        chk("fwd_r4_hit", {31'd0, o_query_hit}, 32'd1);
        chk("fwd_r4_val", {16'd0, o_query_val}, 32'h0002);
        step(1'b0, 1'b1, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 5'd12);
        idle(4, 5'd4);

        // Random traffic with a narrow dest range to provoke kills and forwarding hits
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 2,
                 $urandom_range(99) < 40, 5'($urandom_range(7)), 16'($urandom),
                 $urandom_range(99) < 65, 5'($urandom_range(7)), 16'($urandom),
                 5'($urandom_range(8)));
        end
        idle(8, 5'd0);
        @(negedge clk);
        #1;
        chk("final_drain", exp_q.size(), 32'd0);
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
